echo_canceller: RTL and testbench
=================================

// Module: echo_canceller
// PURPOSE
//  Inverse of the delay-line reverb: removes a single-tap echo y[n] = x[n] + (x[n-D] >>> MIX_SHIFT)
//  by computing x^[n] = sat16(y[n] - (x^[n-D] >>> MIX_SHIFT)). Recursive (IIR): the delay line stores
//  reconstructed outputs, not inputs. Sits on the 16-bit audio path after a reverb-processed
//  capture, one sample per in_valid strobe.
// PARAMETERS
//  DELAY_LENGTH  24000  echo delay D in samples; legal range 4..2**ADDR_W
//  MIX_SHIFT     2      echo attenuation as arithmetic right shift; must match the reverb
//  ADDR_W        15     delay-RAM address width
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  enable      in   1   1 = cancel, 0 = bypass; sampled together with in_valid
//  in_valid    in   1   one-cycle strobe, in_sample valid
//  in_sample   in   16  signed echo-laden sample
//  out_valid   out  1   one-cycle strobe, out_sample updated
//  out_sample  out  16  signed reconstructed sample, held between strobes
//  primed      out  1   1 once D samples are stored and history is real data
// BEHAVIOUR
//  - Reset (async, any time, including mid-stream): out_sample=0, out_valid=0, primed=0, wr_ptr=0,
//    fill_cnt=0, pipeline valids cleared. RAM contents are not cleared. fill_cnt gates stale data instead.
//  - Stage 1 (cycle of in_valid): issue synchronous RAM read at wr_ptr (slot written D samples ago).
//    Register in_sample, enable, and hist_ok = (fill_cnt == DELAY_LENGTH).
//    wr_ptr <= (wr_ptr == DELAY_LENGTH-1) ? 0 : wr_ptr+1. fill_cnt saturates at DELAY_LENGTH.
//  - Stage 2 (next cycle): hist = hist_ok ? rd_data : 0. When enable=1, res = sat16(in - (hist >>> MIX_SHIFT)).
//    When enable=0, res = in. Write res to RAM at the stage-1 address. out_sample<=res, out_valid<=1.
//  - Latency: out_valid asserts exactly 2 cycles after in_valid. Throughput is 1 sample/cycle.
//    Back-to-back strobes are legal. D>=4 guarantees the read slot is never the slot being written.
//  - Arithmetic: 17-bit signed difference, then clamp to [-32768, 32767]. The >>> rounds toward -inf.
//  - The RAM is written in bypass as well, so toggling enable keeps a coherent history.
//    Enable changes take effect per sample, with no glitch on in-flight samples.
//  - primed <= 1 on the stage-1 cycle where fill_cnt reaches DELAY_LENGTH. It stays 1 until reset.
//  - When in_valid=0: no pointer or counter movement, no write, out_valid=0, and out_sample holds.
//  - wrap-around: wr_ptr DELAY_LENGTH-1 -> 0. Address compare uses the parameter, not 2**ADDR_W.
// STRUCTURE
//  - Shared package dsp_audio_pkg: SAMPLE_W=16, SAMPLE_MAX/SAMPLE_MIN constants, sample_t typedef,
//    sat16() function. The reverb and future effects reuse these.
//  - Sub-module delay_ram: simple dual-port RAM, DELAY_LENGTH x 16, synchronous read,
//    one write port and one read port, no reset. Maps to block RAM.
//  - Top level: pointer/fill counter, 2-stage pipeline, saturating subtract.
// TESTING  (bench uses DELAY_LENGTH=4, MIX_SHIFT=2)
//  1. Hold rst_n=0 -> out_sample=0, out_valid=0, primed=0. Release, then strobe 1000 x4 with enable=1
//     -> outputs 1000,1000,1000,1000. primed=1 after the 4th strobe. 5th input 1000 -> output 750.
//  2. Round trip: feed reverb-encoded impulse 4000,0,0,0,1000,0,0,0 -> outputs 4000,0,0,0,0,0,0,0.
//  3. Saturation: history -32768 (-8192 after shift) and input 30000 -> 32767.
//     History 32767 (8191) and input -30000 -> -32768.
//  4. Bypass: enable=0 with input 1234 -> output 1234. Re-enable 4 samples later with input 1234
//     -> output 1234 - 308 = 926.
//  5. Sparse strobes, 0-7 idle cycles between them: results identical to back-to-back.
//     out_valid lags in_valid by exactly 2 cycles. out_sample holds while idle.
//  6. Assert rst_n=0 mid-stream with a sample in stage 2 -> no out_valid, all outputs 0.
//     After release, the first 4 outputs equal the inputs (stale RAM ignored).

Source files
------------

// File: rtl/dsp_audio_pkg.sv
// Shared 16-bit audio definitions: sample type, full-scale limits and the
// saturating narrow from a 17-bit intermediate back to a sample.
package dsp_audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  // Clamp a 17-bit signed value to the 16-bit sample range. Overflow shows up
  // as disagreement between the two top bits.
  function automatic sample_t sat16(input logic signed [SAMPLE_W:0] v);
    if (!v[SAMPLE_W] && v[SAMPLE_W-1]) begin
      return SAMPLE_MAX;
    end else if (v[SAMPLE_W] && !v[SAMPLE_W-1]) begin
      return SAMPLE_MIN;
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port sample memory: one write port, one synchronous read port.
// Written so synthesis maps it onto block RAM.
module delay_ram
  import dsp_audio_pkg::*;
#(
  parameter int DEPTH  = 24000,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  sample_t           wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output sample_t           rdata
);

  sample_t mem [DEPTH];

  // Registered write and registered read on the same clock.
  // NOTE: the array and its read register carry no reset; a reset term would
  // stop the memory mapping to block RAM. Stale contents are gated upstream.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/echo_canceller.sv
// Single-tap echo canceller: x^[n] = sat16(y[n] - (x^[n-D] >>> MIX_SHIFT)).
// The delay line holds reconstructed outputs, so the filter is recursive.
// Two-stage pipeline: stage 1 reads history, stage 2 subtracts and writes back.
module echo_canceller
  import dsp_audio_pkg::*;
#(
  parameter int DELAY_LENGTH = 24000,
  parameter int MIX_SHIFT    = 2,
  parameter int ADDR_W       = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [15:0] in_sample,
  output logic        out_valid,
  output logic [15:0] out_sample,
  output logic        primed
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DELAY_LENGTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DELAY_LENGTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   fill_cnt_q, fill_cnt_d;
  logic              primed_q;

  // Stage-1 registers: the sample in flight while its history read completes.
  logic              s1_valid_q;
  sample_t           s1_sample_q;
  logic              s1_en_q;
  logic              s1_hist_ok_q;
  logic [ADDR_W-1:0] s1_addr_q;

  logic              out_valid_q;
  sample_t           out_sample_q;

  sample_t                   rd_data;
  sample_t                   hist;
  sample_t                   hist_shift;
  logic signed [SAMPLE_W:0]  diff;
  sample_t                   res;

  // Pointer wraps at the delay length; fill counter saturates once full.
  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    if (in_valid) begin
      wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
      if (fill_cnt_q != FULL_CNT) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: advance pointer/counter, capture the sample and its context.
  // NOTE: clocked state uses non-blocking '<=' so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      fill_cnt_q   <= '0;
      primed_q     <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_sample_q  <= '0;
      s1_en_q      <= 1'b0;
      s1_hist_ok_q <= 1'b0;
      s1_addr_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sample_q  <= in_sample;
        s1_en_q      <= enable;
        s1_hist_ok_q <= (fill_cnt_q == FULL_CNT);
        s1_addr_q    <= wr_ptr_q;
        if (fill_cnt_d == FULL_CNT) begin
          primed_q <= 1'b1;
        end
      end
    end
  end

  // Stage 2 datapath: gate unwritten history, attenuate, subtract, clamp.
  always_comb begin
    hist       = s1_hist_ok_q ? rd_data : '0;
    hist_shift = hist >>> MIX_SHIFT;
    diff       = (SAMPLE_W + 1)'(s1_sample_q) - (SAMPLE_W + 1)'(hist_shift);
    res        = s1_en_q ? sat16(diff) : s1_sample_q;
  end

  // Stage 2 output register; the sample holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sample_q <= res;
      end
    end
  end

  // Read the slot written D samples ago; write back the result in bypass too,
  // so the history stays coherent across enable changes.
  delay_ram #(
    .DEPTH  (DELAY_LENGTH),
    .ADDR_W (ADDR_W)
  ) u_delay_ram (
    .clk   (clk),
    .we    (s1_valid_q),
    .waddr (s1_addr_q),
    .wdata (res),
    .re    (in_valid),
    .raddr (wr_ptr_q),
    .rdata (rd_data)
  );

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign primed     = primed_q;

endmodule

// File: tb/tb_echo_canceller.sv
// Directed bench for echo_canceller with D=4, MIX_SHIFT=2.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_echo_canceller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        in_valid;
  logic [15:0] in_sample;
  logic        out_valid;
  logic [15:0] out_sample;
  logic        primed;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  echo_canceller #(
    .DELAY_LENGTH (4),
    .MIX_SHIFT    (2),
    .ADDR_W       (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .primed     (primed)
  );

  // One cycle: sample outputs at the falling edge, then drive new inputs.
  task automatic step(input logic v, input logic en, input int x,
                      output logic ov, output logic [15:0] os, output logic pr);
    @(negedge clk);
    ov        = out_valid;
    os        = out_sample;
    pr        = primed;
    in_valid  = v;
    enable    = en;
    in_sample = 16'(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    enable    = 1'b1;
    in_sample = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    enable    = 1'b1;
    in_sample = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_sample !== 16'd0) begin
      failures++;
      $display("FAIL reset_out_sample got=%0d want=0", $signed(out_sample));
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%0b want=0", out_valid);
    end
    checks++;
    if (primed !== 1'b0) begin
      failures++;
      $display("FAIL reset_primed got=%0b want=0", primed);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    int vexp[5] = '{1000, 1000, 1000, 1000, 750};
    logic ov, pr;
    logic [15:0] os;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) step(1'b1, 1'b1, 1000, ov, os, pr);
      else       step(1'b0, 1'b1, 0, ov, os, pr);
      if (i == 3 || i == 4) begin
        checks++;
        if (pr !== (i == 4)) begin
          failures++;
          $display("FAIL fill_primed[%0d] got=%0b want=%0b", i, pr, (i == 4));
        end
      end
      if (i >= 2) begin
        checks++;
        if (ov !== 1'b1 || os !== 16'(vexp[i-2])) begin
          failures++;
          $display("FAIL fill[%0d] valid=%0b sample=%0d want valid=1 sample=%0d",
                   i - 2, ov, $signed(os), vexp[i-2]);
        end
      end
    end
  endtask

  task automatic test_round_trip();
    int vin[8]  = '{4000, 0, 0, 0, 1000, 0, 0, 0};
    int vexp[8] = '{4000, 0, 0, 0, 0, 0, 0, 0};
    logic ov, pr;
    logic [15:0] os;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) step(1'b1, 1'b1, vin[i], ov, os, pr);
      else       step(1'b0, 1'b1, 0, ov, os, pr);
      if (i >= 2) begin
        checks++;
        if (ov !== 1'b1 || os !== 16'(vexp[i-2])) begin
          failures++;
          $display("FAIL round_trip[%0d] valid=%0b sample=%0d want valid=1 sample=%0d",
                   i - 2, ov, $signed(os), vexp[i-2]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int vin[9]  = '{-32768, 0, 0, 0, 30000, 0, 0, 0, -30000};
    int vexp[9] = '{-32768, 0, 0, 0, 32767, 0, 0, 0, -32768};
    logic ov, pr;
    logic [15:0] os;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (i < 9) step(1'b1, 1'b1, vin[i], ov, os, pr);
      else       step(1'b0, 1'b1, 0, ov, os, pr);
      if (i >= 2) begin
        checks++;
        if (ov !== 1'b1 || os !== 16'(vexp[i-2])) begin
          failures++;
          $display("FAIL saturation[%0d] valid=%0b sample=%0d want valid=1 sample=%0d",
                   i - 2, ov, $signed(os), vexp[i-2]);
        end
      end
    end
  endtask

  task automatic test_bypass();
    int   vin[6]  = '{1234, 400, 0, 0, 1234, 500};
    logic ven[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int   vexp[6] = '{1234, 400, 0, 0, 926, 500};
    logic ov, pr;
    logic [15:0] os;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 6) step(1'b1, ven[i], vin[i], ov, os, pr);
      else       step(1'b0, 1'b1, 0, ov, os, pr);
      if (i >= 2) begin
        checks++;
        if (ov !== 1'b1 || os !== 16'(vexp[i-2])) begin
          failures++;
          $display("FAIL bypass[%0d] valid=%0b sample=%0d want valid=1 sample=%0d",
                   i - 2, ov, $signed(os), vexp[i-2]);
        end
      end
    end
  endtask

  // Negative history exercises the round-toward-minus-infinity shift.
  task automatic test_back_to_back();
    int vin[8]  = '{-1, -5, 7, 0, 0, 0, 0, 0};
    int vexp[8] = '{-1, -5, 7, 0, 1, 2, -1, 0};
    logic ov, pr;
    logic [15:0] os;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) step(1'b1, 1'b1, vin[i], ov, os, pr);
      else       step(1'b0, 1'b1, 0, ov, os, pr);
      if (i >= 2) begin
        checks++;
        if (ov !== 1'b1 || os !== 16'(vexp[i-2])) begin
          failures++;
          $display("FAIL back_to_back[%0d] valid=%0b sample=%0d want valid=1 sample=%0d",
                   i - 2, ov, $signed(os), vexp[i-2]);
        end
      end
    end
  endtask

  // Idle gaps of 0..7 cycles; every cycle checks the 2-cycle valid lag and
  // that out_sample holds while idle.
  task automatic test_sparse();
    int   vin[8]  = '{100, 200, 300, 400, 500, 600, 700, 800};
    int   vexp[8] = '{100, 200, 300, 400, 475, 550, 625, 700};
    int   gap[8]  = '{0, 3, 7, 1, 5, 2, 6, 4};
    logic sv[$];
    int   sx[$];
    int   se[$];
    int   last = 0;
    logic ov, pr, exp_v;
    logic [15:0] os;
    for (int s = 0; s < 8; s++) begin
      for (int g = 0; g < gap[s]; g++) begin
        sv.push_back(1'b0); sx.push_back(0); se.push_back(0);
      end
      sv.push_back(1'b1); sx.push_back(vin[s]); se.push_back(vexp[s]);
    end
    for (int k = 0; k < 2; k++) begin
      sv.push_back(1'b0); sx.push_back(0); se.push_back(0);
    end
    do_reset();
    for (int j = 0; j < sv.size(); j++) begin
      step(sv[j], 1'b1, sx[j], ov, os, pr);
      exp_v = (j >= 2) ? sv[j-2] : 1'b0;
      if (exp_v) last = se[j-2];
      checks++;
      if (ov !== exp_v || os !== 16'(last)) begin
        failures++;
        $display("FAIL sparse[cycle %0d] valid=%0b sample=%0d want valid=%0b sample=%0d",
                 j, ov, $signed(os), exp_v, last);
      end
    end
  endtask

  task automatic test_midstream_reset();
    int vin[5]  = '{11, 22, 33, 44, 55};
    int vexp[5] = '{11, 22, 33, 44, 53};
    logic ov, pr;
    logic [15:0] os;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1000, ov, os, pr);
    // Sample 4 is now in stage 2; kill it with an asynchronous reset.
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sample !== 16'd0 || primed !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs valid=%0b sample=%0d primed=%0b want 0/0/0",
               out_valid, $signed(out_sample), primed);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_sample !== 16'd0) begin
        failures++;
        $display("FAIL midreset_hold[%0d] valid=%0b sample=%0d want 0/0",
                 k, out_valid, $signed(out_sample));
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) step(1'b1, 1'b1, vin[i], ov, os, pr);
      else       step(1'b0, 1'b1, 0, ov, os, pr);
      if (i >= 2) begin
        checks++;
        if (ov !== 1'b1 || os !== 16'(vexp[i-2])) begin
          failures++;
          $display("FAIL after_reset[%0d] valid=%0b sample=%0d want valid=1 sample=%0d",
                   i - 2, ov, $signed(os), vexp[i-2]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_round_trip();
    test_saturation();
    test_bypass();
    test_back_to_back();
    test_sparse();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
